// File: rtl/conv3x3_pkg.sv
// conv3x3_pkg -- shared constants for the streaming 3x3 Gaussian filter.
//
// Contents:
//   K_CORNER/K_EDGE/K_CENTRE : kernel weights (1-2-1 / 2-4-2 / 1-2-1)
//   SUM_SHIFT                : normalisation shift (divide by 16)
//   ROUND_ADD                : half-LSB offset used when rounding is enabled
//   cnt_w()                  : counter width helper (clog2, minimum 1)
package conv3x3_pkg;

  localparam int K_CORNER  = 1;
  localparam int K_EDGE    = 2;
  localparam int K_CENTRE  = 4;
  localparam int SUM_SHIFT = 4;
  localparam int ROUND_ADD = 8;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_ram.sv
// line_ram -- single-port, read-first synchronous RAM with two write lanes.
//
// The word is split into two equal halves that can be written independently,
// so the filter can replace only the oldest stored row while reading both.
//
// Ports:
//   clk   : clock
//   en    : access enable; when low, rdata and memory contents hold
//   we    : per-half write enable (bit 0 = low half, bit 1 = high half)
//   addr  : word address
//   wdata : write data (only enabled halves are stored)
//   rdata : registered read data, returns the contents before the write
module line_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [1:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  localparam int HW = WIDTH / 2;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we[0]) mem[addr][HW-1:0]     <= wdata[HW-1:0];
      if (we[1]) mem[addr][WIDTH-1:HW] <= wdata[WIDTH-1:HW];
    end
  end

endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream -- streaming 3x3 Gaussian filter (1-2-1/2-4-2/1-2-1, /16).
//
// Accepts one raster-order pixel per clock and emits only interior pixels,
// (IMG_W-2)*(IMG_H-2) per frame, two enabled cycles after the completing
// pixel is accepted. The whole pipe advances on en = s_ready.
//
// Build option: define CONV3X3_ROUND_EN for round-half-up (sum+8)>>4;
// otherwise the result is truncated (sum>>4).
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   s_valid/s_ready   : input handshake; s_data pixel, s_sof forces (0,0)
//   m_valid/m_ready   : output handshake; m_data filtered pixel
//   m_last            : marks the final output of a frame
//   done              : one-cycle pulse after the m_last handshake
module conv3x3_stream
  import conv3x3_pkg::*;
#(
  parameter int DW    = 16,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_sof,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          done
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam int SW = DW + 4;

  logic          en;
  logic          acc;
  logic [CW-1:0] col_reg, cur_col;
  logic [RW-1:0] row_reg, cur_row;

  assign s_ready = !m_valid || m_ready;
  assign en      = s_ready;
  assign acc     = s_valid && en;

  // s_sof overrides the counters so a resync pixel is always (0,0).
  always_comb begin
    cur_col = s_sof ? '0 : col_reg;
    cur_row = s_sof ? '0 : row_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (acc) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col_reg <= '0;
        row_reg <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_reg <= cur_col + CW'(1);
        row_reg <= cur_row;
      end
    end
  end

  // Even rows live in the low half, odd rows in the high half. Writing the
  // current pixel over its own parity slot replaces row r-2 while the
  // read-first port still returns both older rows for this column.
  logic [2*DW-1:0] ram_rdata;

  line_ram #(
    .DEPTH (IMG_W),
    .WIDTH (2 * DW)
  ) u_line_ram (
    .clk   (clk),
    .en    (acc),
    .we    (cur_row[0] ? 2'b10 : 2'b01),
    .addr  (cur_col),
    .wdata ({s_data, s_data}),
    .rdata (ram_rdata)
  );

  // Stage 1: RAM data returns, window shifts in the new column.
  logic          s1_valid, s1_out, s1_last, s1_odd;
  logic [DW-1:0] s1_pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_out   <= 1'b0;
      s1_last  <= 1'b0;
      s1_odd   <= 1'b0;
      s1_pix   <= '0;
    end else if (en) begin
      s1_valid <= acc;
      s1_out   <= acc && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      s1_last  <= acc && (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
      if (acc) begin
        s1_pix <= s_data;
        s1_odd <= cur_row[0];
      end
    end
  end

  logic [DW-1:0] col_in [3];

  always_comb begin
    col_in[0] = s1_odd ? ram_rdata[2*DW-1:DW] : ram_rdata[DW-1:0];
    col_in[1] = s1_odd ? ram_rdata[DW-1:0]    : ram_rdata[2*DW-1:DW];
    col_in[2] = s1_pix;
  end

  // Window row gi: tap[2] is the newest column, tap[0] the oldest.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DW-1:0] tap [3];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tap[0] <= '0;
          tap[1] <= '0;
          tap[2] <= '0;
        end else if (en && s1_valid) begin
          tap[0] <= tap[1];
          tap[1] <= tap[2];
          tap[2] <= col_in[gi];
        end
      end
    end
  endgenerate

  logic s2_out, s2_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_out  <= 1'b0;
      s2_last <= 1'b0;
    end else if (en) begin
      s2_out  <= s1_valid && s1_out;
      s2_last <= s1_valid && s1_last;
    end
  end

  // Stage 2 arithmetic: full-precision sum, max 16*(2^DW-1) fits in DW+4.
  logic [SW-1:0] sum_corner, sum_edge, sum, sum_adj;
  logic [DW-1:0] result;

  always_comb begin
    sum_corner = SW'(g_row[0].tap[0]) + SW'(g_row[0].tap[2])
               + SW'(g_row[2].tap[0]) + SW'(g_row[2].tap[2]);
    sum_edge   = SW'(g_row[0].tap[1]) + SW'(g_row[1].tap[0])
               + SW'(g_row[1].tap[2]) + SW'(g_row[2].tap[1]);
    sum        = SW'(K_CORNER) * sum_corner + SW'(K_EDGE) * sum_edge
               + SW'(K_CENTRE) * SW'(g_row[1].tap[1]);
`ifdef CONV3X3_ROUND_EN
    sum_adj    = sum + SW'(ROUND_ADD);
`else
    sum_adj    = sum;
`endif
    result     = DW'(sum_adj >> SUM_SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= m_valid && m_ready && m_last;
      if (en) begin
        m_valid <= s2_out;
        m_last  <= s2_out && s2_last;
        if (s2_out) m_data <= result;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream -- self-checking bench for conv3x3_stream (DW=8, 8x6).
// A bench-side frame store computes each expected output when the
// completing pixel is accepted; outputs are popped and compared in order.
module tb_conv3x3_stream;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
`ifdef CONV3X3_ROUND_EN
  localparam int RND = 8;
`else
  localparam int RND = 0;
`endif

  logic          clk, rst;
  logic          s_valid, s_ready, s_sof;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_last, done;
  logic [DW-1:0] m_data;

  conv3x3_stream #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    int last;
    int r;
    int c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   img [H][W];
  int   obs [H][W];
  int   mod_row = 0, mod_col = 0;
  int   out_cnt = 0, done_cnt = 0;
  int   exp_done = 0;
  bit   stall_prev = 0;
  int   held = 0;
  bit   last_acc = 0;
  bit   sready_always = 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int gauss(input int r, input int c);
    int s;
    s = img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]
      + 2*img[r-1][c-2] + 4*img[r-1][c-1] + 2*img[r-1][c]
      + img[r][c-2] + 2*img[r][c-1] + img[r][c];
    return (s + RND) >> 4;
  endfunction

  // One clock: drive inputs after the falling edge, sample 1ns later,
  // then wait for the next falling edge (the rising edge lies between).
  task automatic step(input bit v, input int d, input bit sof, input bit mrdy);
    exp_t e;
    int r, c;
    s_valid = v; s_data = DW'(d); s_sof = sof; m_ready = mrdy;
    #1;
    check("done", int'(done), exp_done);
    if (done) done_cnt++;
    exp_done = 0;
    if (stall_prev) begin
      check("hold_valid", int'(m_valid), 1);
      check("hold_data", int'(m_data), held);
    end
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("data", int'(m_data), e.data);
        check("last", int'(m_last), e.last);
        obs[e.r][e.c] = int'(m_data);
        exp_done = e.last;
        $display("out r=%0d c=%0d data=%0d exp=%0d last=%0d", e.r, e.c, m_data, e.data, m_last);
      end
      out_cnt++;
    end
    stall_prev = m_valid && !m_ready;
    held = int'(m_data);
    if (!s_ready) sready_always = 0;
    last_acc = s_valid && s_ready;
    if (last_acc) begin
      r = sof ? 0 : mod_row;
      c = sof ? 0 : mod_col;
      img[r][c] = d;
      if (r >= 2 && c >= 2) begin
        e.data = gauss(r, c);
        e.last = (r == H-1 && c == W-1) ? 1 : 0;
        e.r = r; e.c = c;
        sb.push_back(e);
      end
      if (c == W-1) begin
        mod_col = 0;
        mod_row = (r == H-1) ? 0 : r + 1;
      end else begin
        mod_col = c + 1;
        mod_row = r;
      end
    end
    @(negedge clk);
  endtask

  task automatic feed_pixel(input int d, input bit sof, input bit rmode);
    int tries = 0;
    do begin
      step(1'b1, d, sof, rmode ? bit'($urandom_range(0, 1)) : 1'b1);
      tries++;
    end while (!last_acc && tries < 1000);
    if (!last_acc) check("accept_timeout", tries, 0);
  endtask

  // mode 0: constant val, 1: impulse 255 at (3,3), 2: random
  task automatic feed_frame(input int mode, input int val, input bit sof, input bit rmode);
    int d;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0: d = val;
          1: d = (r == 3 && c == 3) ? 255 : 0;
          default: d = int'($urandom_range(0, 255));
        endcase
        feed_pixel(d, sof && r == 0 && c == 0, rmode);
      end
    end
  endtask

  task automatic flush(input bit rmode);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      step(1'b0, 0, 1'b0, rmode ? bit'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    if (sb.size() != 0) check("flush_timeout", sb.size(), 0);
    repeat (3) step(1'b0, 0, 1'b0, 1'b1);
  endtask

  int o0, d0;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; m_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data",  int'(m_data), 0);
    check("rst_m_last",  int'(m_last), 0);
    check("rst_done",    int'(done), 0);
    check("rst_s_ready", int'(s_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Constant frame, sink always ready.
    o0 = out_cnt; d0 = done_cnt; sready_always = 1;
    feed_frame(0, 100, 1'b0, 1'b0);
    flush(1'b0);
    check("t1_count", out_cnt - o0, 24);
    check("t1_done", done_cnt - d0, 1);
    check("t1_s_ready", int'(sready_always), 1);

    // Single impulse.
    o0 = out_cnt; d0 = done_cnt;
    feed_frame(1, 0, 1'b0, 1'b0);
    flush(1'b0);
    check("t2_count", out_cnt - o0, 24);
    check("t2_centre", obs[4][4], (RND != 0) ? 64 : 63);
    check("t2_edge_n", obs[3][4], (RND != 0) ? 32 : 31);
    check("t2_edge_w", obs[4][3], (RND != 0) ? 32 : 31);
    check("t2_corner_nw", obs[3][3], (RND != 0) ? 16 : 15);
    check("t2_corner_se", obs[5][5], (RND != 0) ? 16 : 15);
    check("t2_far", obs[5][7], 0);

    // Random pixels, random backpressure.
    o0 = out_cnt; d0 = done_cnt;
    feed_frame(2, 0, 1'b0, 1'b1);
    feed_frame(2, 0, 1'b0, 1'b1);
    flush(1'b1);
    check("t3_count", out_cnt - o0, 48);
    check("t3_done", done_cnt - d0, 2);

    // Back-to-back frames of different constants.
    o0 = out_cnt; d0 = done_cnt;
    feed_frame(0, 10, 1'b0, 1'b0);
    feed_frame(0, 200, 1'b0, 1'b0);
    flush(1'b0);
    check("t4_count", out_cnt - o0, 48);
    check("t4_done", done_cnt - d0, 2);
    check("t4_first", obs[2][2], 200);
    check("t4_lastpix", obs[5][7], 200);

    // Resync with s_sof at (2,5) of a partial frame.
    d0 = done_cnt;
    for (int i = 0; i < 2*W + 5; i++) feed_pixel(int'($urandom_range(0, 255)), 1'b0, 1'b0);
    flush(1'b0);
    o0 = out_cnt;
    feed_frame(0, 50, 1'b1, 1'b0);
    flush(1'b0);
    check("t5_count", out_cnt - o0, 24);
    check("t5_done", done_cnt - d0, 1);

    // Reset mid-frame while output is valid.
    for (int i = 0; i < 30; i++) feed_pixel(77, 1'b0, 1'b0);
    s_valid = 1'b0;
    #1;
    check("t6_pre_valid", int'(m_valid), 1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", int'(m_valid), 0);
    check("t6_rst_last", int'(m_last), 0);
    check("t6_rst_done", int'(done), 0);
    sb.delete();
    mod_row = 0; mod_col = 0; exp_done = 0; stall_prev = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    o0 = out_cnt; d0 = done_cnt;
    feed_frame(2, 0, 1'b0, 1'b0);
    flush(1'b0);
    check("t6_count", out_cnt - o0, 24);
    check("t6_done", done_cnt - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
